// File: rtl/key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// key_debounce_ctrl
//
// Debounces WIDTH active-low push-button inputs and exposes them through a
// small Avalon-MM slave with a level interrupt on key presses.
//
// Ports
//   clk        sole clock, everything updates on its rising edge
//   reset_n    asynchronous active-low reset
//   address    register select: 0 data (db), 1 raw (sync), 2 irq_mask,
//              3 edge (write-1-to-clear)
//   write      write strobe, one cycle per write
//   writedata  write data (only bits WIDTH-1:0 are used)
//   readdata   registered read data, one cycle after address
//   in_port    raw asynchronous key levels, 0 = pressed
//   irq        OR of masked edge flags, driven from registers only
// ---------------------------------------------------------------------------
module key_debounce_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Next stability count. The count restarts whenever the input agrees with
    // the debounced level and also on the accepting cycle, so it never wraps.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             differs
    );
        if (!differs || cur == CNT_LAST) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] db;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] edge_flags;
    logic [WIDTH-1:0] edge_nxt;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] irq_mask;
    logic [31:0]      rd_mux;
    logic             wr_mask;
    logic             wr_clr;

    // Per-bit debounce decision on the synchronized level.
    always_comb begin
        cnt_nxt = cnt;
        db_nxt  = db;
        press   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt_next(cnt[i], sync_p1[i] != db[i]);
            if (sync_p1[i] != db[i] && cnt[i] == CNT_LAST) begin
                db_nxt[i] = sync_p1[i];
                // Only a 1->0 acceptance is a press; releases never flag.
                press[i]  = ~sync_p1[i];
            end
        end
    end

    // Register writes. A press landing in the same cycle as a clear wins.
    always_comb begin
        wr_mask  = write && (address == 2'd2);
        wr_clr   = write && (address == 2'd3);
        clr_mask = wr_clr ? writedata[WIDTH-1:0] : '0;
        edge_nxt = (edge_flags & ~clr_mask) | press;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(db);
            2'd1:    rd_mux = 32'(sync_p1);
            2'd2:    rd_mux = 32'(irq_mask);
            default: rd_mux = 32'(edge_flags);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0    <= '1;
            sync_p1    <= '1;
            db         <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            edge_flags <= '0;
            irq_mask   <= '0;
            readdata   <= '0;
        end else begin
            // stage p0/p1: two-flop synchronizer
            sync_p0    <= in_port;
            sync_p1    <= sync_p0;
            // stage: debounce state and edge flags
            db         <= db_nxt;
            cnt        <= cnt_nxt;
            edge_flags <= edge_nxt;
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // stage: registered read port
            readdata   <= rd_mux;
        end
    end

    assign irq = |(edge_flags & irq_mask);

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_ctrl
//
// Directed bench for key_debounce_ctrl with WIDTH = 2, DEBOUNCE_CYCLES = 4.
// The stimulus process queues expected readdata / irq values tagged with the
// clock cycle at which they must appear; a monitor on the falling edge pops
// and compares them.
// ---------------------------------------------------------------------------
module tb_key_debounce_ctrl;

    localparam int K_READ = 0;
    localparam int K_IRQ  = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t       sb[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done   = 1'b0;
    logic [31:0] act;

    key_debounce_ctrl #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due in this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                act = (sb[i].kind == K_READ) ? readdata : {31'b0, irq};
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc || done) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(input int c, input int k, input logic [31:0] e, input string n);
        item_t it;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        it.name = n;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step();
        write     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int t;
        int r;
        reset_n   = 1'b0;
        in_port   = 2'b11;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 32'h0;

        // Reset state
        step();
        push(cyc, K_READ, 32'h0, "rst_readdata");
        push(cyc, K_IRQ,  32'h0, "rst_irq");
        steps(2);
        reset_n = 1'b1;
        push(cyc + 1, K_READ, 32'h3, "idle_data");
        step();
        address = 2'd1;
        push(cyc + 1, K_READ, 32'h3, "idle_raw");
        push(cyc,     K_IRQ,  32'h0, "idle_irq");
        step();

        // Press key 0: accepted exactly 2 + 4 clocks after the input change
        address = 2'd0;
        in_port = 2'b10;
        t = cyc;
        push(t + 6, K_READ, 32'h3, "data_before_accept");
        push(t + 7, K_READ, 32'h2, "data_accepted");
        steps(7);
        address = 2'd3;
        push(cyc + 1, K_READ, 32'h1, "edge_press0");
        push(cyc,     K_IRQ,  32'h0, "irq_mask0");
        step();

        // Mask on -> irq; write-1-clear -> irq off
        wr(2'd2, 32'h1);
        push(cyc,     K_IRQ,  32'h1, "irq_masked");
        push(cyc + 1, K_READ, 32'h1, "mask_readback");
        step();
        wr(2'd3, 32'h1);
        push(cyc,     K_READ, 32'h1, "edge_pre_clear");
        push(cyc,     K_IRQ,  32'h0, "irq_cleared");
        push(cyc + 1, K_READ, 32'h0, "edge_cleared");
        step();

        // Writes to read-only registers change nothing
        wr(2'd0, 32'h0);
        push(cyc + 1, K_READ, 32'h2, "wr_data_ignored");
        step();
        wr(2'd1, 32'h0);
        push(cyc + 1, K_READ, 32'h2, "wr_raw_ignored");
        step();

        // Bounce on key 1: three low cycles is one short of acceptance
        in_port = 2'b00;
        steps(3);
        in_port = 2'b10;
        steps(8);
        address = 2'd0;
        push(cyc + 1, K_READ, 32'h2, "bounce_data");
        step();
        address = 2'd3;
        push(cyc + 1, K_READ, 32'h0, "bounce_edge");
        step();

        // Key 1 acceptance collides with a write-1-clear of edge[1]
        in_port = 2'b00;
        t = cyc;
        steps(5);
        writedata = 32'h2;
        write     = 1'b1;
        step();
        write     = 1'b0;
        push(t + 6, K_READ, 32'h0, "edge_pre_accept1");
        push(t + 7, K_READ, 32'h2, "edge_set_wins");
        push(t + 7, K_IRQ,  32'h0, "irq_bit1_unmasked");
        step();
        address = 2'd0;
        push(cyc + 1, K_READ, 32'h0, "data_both_pressed");
        step();
        wr(2'd2, 32'h3);
        push(cyc, K_IRQ, 32'h1, "irq_bit1_masked");
        step();

        // Release both keys: no edge from a release
        in_port = 2'b11;
        t = cyc;
        address = 2'd0;
        push(t + 7, K_READ, 32'h3, "data_released");
        steps(8);
        address = 2'd3;
        push(cyc + 1, K_READ, 32'h2, "edge_release_none");
        push(cyc,     K_IRQ,  32'h1, "irq_held");
        step();

        // Asynchronous reset mid-count, key 0 held across reset release
        in_port = 2'b10;
        steps(3);
        push(cyc, K_IRQ, 32'h1, "irq_before_rst");
        step();
        reset_n = 1'b0;
        push(cyc, K_READ, 32'h0, "rst_async_readdata");
        push(cyc, K_IRQ,  32'h0, "rst_async_irq");
        step();
        reset_n = 1'b1;
        r = cyc;
        address = 2'd2;
        push(r + 1, K_READ, 32'h0, "rst_mask");
        step();
        address = 2'd3;
        push(r + 2, K_READ, 32'h0, "rst_edge");
        step();
        address = 2'd0;
        push(r + 6, K_READ, 32'h3, "rst_db_released");
        push(r + 7, K_READ, 32'h2, "held_press_db");
        steps(5);
        address = 2'd3;
        push(r + 8, K_READ, 32'h1, "held_press_edge");
        push(r + 7, K_IRQ,  32'h0, "irq_after_rst");
        steps(3);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
